// File: rtl/permute_pkg.sv
// Shared permutation-mode encoding and skid-buffer state type; the load/store unit uses the same mode values.
// No logic. Backpressure: n/a.
package permute_pkg;

    typedef logic [1:0] perm_mode_t;

    localparam perm_mode_t PERM_PASS      = 2'd0;
    localparam perm_mode_t PERM_BIT_REV   = 2'd1;
    localparam perm_mode_t PERM_LANE_SWAP = 2'd2;
    localparam perm_mode_t PERM_HALF_SWAP = 2'd3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/permute_net.sv
// Combinational permutation network: pass, bit reverse, lane swap, half swap.
// Latency: 0 (pure combinational). Backpressure: none.
module permute_net
    import permute_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] in_dat,
    input  perm_mode_t            mode,
    output logic [DATA_WIDTH-1:0] out_dat
);

    localparam int W = DATA_WIDTH;
    localparam int N = DATA_WIDTH / LANE_WIDTH;
    localparam int H = DATA_WIDTH / 2;

    logic [W-1:0] rev_dat;
    logic [W-1:0] lane_dat;
    logic [W-1:0] half_dat;

    generate
        if (W < 2) begin : g_chk_width
            $error("data_permuter: DATA_WIDTH must be at least 2");
        end
        if ((W % LANE_WIDTH) != 0) begin : g_chk_lane
            $error("data_permuter: DATA_WIDTH must be a multiple of LANE_WIDTH");
        end

        for (genvar i = 0; i < W; i++) begin : g_rev
            assign rev_dat[i] = in_dat[W-1-i];
        end

        for (genvar k = 0; k < N; k++) begin : g_lane
            assign lane_dat[k*LANE_WIDTH +: LANE_WIDTH] = in_dat[(N-1-k)*LANE_WIDTH +: LANE_WIDTH];
        end

        // Upper and lower floor(W/2) bits exchange; for odd W the centre bit stays put.
        for (genvar i = 0; i < H; i++) begin : g_half
            assign half_dat[i]       = in_dat[W-H+i];
            assign half_dat[W-H+i]   = in_dat[i];
        end
        if ((W % 2) != 0) begin : g_mid
            assign half_dat[H] = in_dat[H];
        end
    endgenerate

    always_comb begin
        out_dat = in_dat;
        case (mode)
            PERM_BIT_REV:   out_dat = rev_dat;
            PERM_LANE_SWAP: out_dat = lane_dat;
            PERM_HALF_SWAP: out_dat = half_dat;
            default:        out_dat = in_dat;
        endcase
    end

endmodule

// File: rtl/data_permuter.sv
// Registered data permuter with 2-entry skid buffer; optional xfer_count via DATA_PERMUTER_STATS_EN.
// Latency: 1 cycle, full throughput. Backpressure: in_ready is a register, low only while the skid entry is full.
module data_permuter
    import permute_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  perm_mode_t            in_mode,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef DATA_PERMUTER_STATS_EN
    output logic [31:0]           xfer_count,
`endif
    output logic [DATA_WIDTH-1:0] out_data
);

    skid_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] main_dat_q, main_dat_d;
    logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic                  rdy_q, rdy_d;
    logic [DATA_WIDTH-1:0] perm_dat;
    logic                  accept;
    logic                  emit;

    permute_net #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_net (
        .in_dat  (in_data),
        .mode    (in_mode),
        .out_dat (perm_dat)
    );

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_dat_q;
    assign accept    = in_valid && rdy_q;
    assign emit      = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        main_dat_d = main_dat_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_dat_d = perm_dat;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_dat_d = perm_dat;
                    end else if (accept) begin
                        skid_dat_d = perm_dat;
                        state_d    = ST_FULL;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // rdy_q is low here, so no accept can coincide with the skid drain.
                    if (emit) begin
                        main_dat_d = skid_dat_q;
                        state_d    = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_dat_q <= '0;
            skid_dat_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
            rdy_q      <= rdy_d;
        end
    end

`ifdef DATA_PERMUTER_STATS_EN
    logic [31:0] xfer_cnt_q;

    // A flushed cycle is not a transfer, so it is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else if (emit && !flush) begin
            xfer_cnt_q <= xfer_cnt_q + 32'd1;
        end
    end

    assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_data_permuter.sv
// Scoreboard bench for data_permuter: random and directed traffic against a behavioural permutation model.
module tb_data_permuter;
    import permute_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    perm_mode_t  in_mode = PERM_PASS;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef DATA_PERMUTER_STATS_EN
    logic [31:0] xfer_count;
    logic [31:0] xfer_exp = '0;
`endif

    logic        in_valid7 = 1'b0;
    logic        in_ready7;
    perm_mode_t  in_mode7 = PERM_BIT_REV;
    logic [6:0]  in_data7 = '0;
    logic        out_valid7;
    logic [6:0]  out_data7;

    logic [31:0] sb[$];
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    data_permuter #(.DATA_WIDTH(32), .LANE_WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DATA_PERMUTER_STATS_EN
        .xfer_count(xfer_count),
`endif
        .out_data  (out_data)
    );

    data_permuter #(.DATA_WIDTH(7), .LANE_WIDTH(7)) u_dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .in_valid  (in_valid7),
        .in_ready  (in_ready7),
        .in_mode   (in_mode7),
        .in_data   (in_data7),
        .out_valid (out_valid7),
        .out_ready (1'b1),
`ifdef DATA_PERMUTER_STATS_EN
        .xfer_count(),
`endif
        .out_data  (out_data7)
    );

    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (m)
            2'd1: for (int i = 0; i < 32; i++) r[i] = d[31-i];
            2'd2: r = {d[7:0], d[15:8], d[23:16], d[31:24]};
            2'd3: r = {d[15:0], d[31:16]};
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus side of the scoreboard: every accepted word pushes its expected image.
    always @(negedge clk) begin
        if (rst_n && !flush && in_valid && in_ready)
            sb.push_back(model(in_mode, in_data));
    end

    // Monitor: pops and compares whenever the DUT hands over a word.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
`ifdef DATA_PERMUTER_STATS_EN
            xfer_exp = '0;
`endif
        end else if (flush) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected: got output %h, required no output", out_data);
            end else begin
                chk("sb_data", out_data, sb.pop_front());
            end
`ifdef DATA_PERMUTER_STATS_EN
            xfer_exp = xfer_exp + 32'd1;
`endif
        end
    end

    logic [31:0] exp_modes [4] = '{32'h12345678, 32'h1E6A2C48, 32'h78563412, 32'h56781234};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
`ifdef DATA_PERMUTER_STATS_EN
        chk("xfer_init", xfer_count, 32'd0);
`endif

        // Directed modes, one cycle after accept
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            in_valid = 1'b1;
            in_mode  = perm_mode_t'(m);
            in_data  = 32'h12345678;
            step();
            chk("mode_valid", {31'd0, out_valid}, 32'd1);
            chk("mode_data", out_data, exp_modes[m]);
        end
        in_valid = 1'b0;

        // Odd width on the 7-bit instance
        in_valid7 = 1'b1;
        in_mode7  = PERM_BIT_REV;
        in_data7  = 7'b1100100;
        step();
        chk("w7_bitrev", {25'd0, out_data7}, {25'd0, 7'b0010011});
        in_mode7 = PERM_HALF_SWAP;
        step();
        chk("w7_halfswap", {25'd0, out_data7}, {25'd0, 7'b1000110});
        in_valid7 = 1'b0;
        step();

        // Streaming, no bubbles
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_mode  = PERM_BIT_REV;
            in_data  = 32'(i);
            step();
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        step();

        // Randomized traffic with occasional flush
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mode   = perm_mode_t'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rand_drained", sb.size(), 32'd0);

        // Backpressure into FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = PERM_LANE_SWAP;
        in_data   = 32'hAABBCCDD;
        step();
        chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
        chk("bp_data_one", out_data, 32'hDDCCBBAA);
        in_data = 32'h11223344;
        step();
        in_valid = 1'b0;
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_hold", out_data, 32'hDDCCBBAA);
        step();
        chk("bp_hold2", out_data, 32'hDDCCBBAA);
        chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_second", out_data, 32'h44332211);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Flush with FULL buffer and a same-cycle input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = PERM_PASS;
        in_data   = 32'hCAFE0001;
        step();
        in_data = 32'hCAFE0002;
        step();
        in_data = 32'hCAFE0003;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_quiet", {31'd0, out_valid}, 32'd0);
        end

        // Flush in ONE with an accept in the same cycle
        in_valid = 1'b1;
        in_data  = 32'hBEEF0001;
        out_ready = 1'b0;
        step();
        in_data = 32'hBEEF0002;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_one_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("flush_one_quiet", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream, between edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = PERM_HALF_SWAP;
        in_data   = 32'h0BAD0001;
        step();
        in_data = 32'h0BAD0002;
        step();
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd0);
        step();
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("arst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        chk("arst_ready_back", {31'd0, in_ready}, 32'd1);
`ifdef DATA_PERMUTER_STATS_EN
        chk("arst_xfer", xfer_count, 32'd0);
`endif

        // Short post-reset traffic then final drain
        for (int c = 0; c < 40; c++) begin
            in_valid  = ($urandom_range(0, 1) != 0);
            in_mode   = perm_mode_t'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("final_drained", sb.size(), 32'd0);
`ifdef DATA_PERMUTER_STATS_EN
        chk("xfer_count", xfer_count, xfer_exp);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
